// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: one write pulse the cycle after each 4th data byte; the core is released 2 cycles after the last byte.
// Backpressure: in_ready is high while loading (HDR/DATA/CHK) and low in RUN/ERROR; it never depends on in_valid.
// Optional feature: define CHECKSUM_EN to add the trailing XOR checksum byte (CHK/ERROR states).
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  reload,
   output logic                  im_wren,
   output logic [ADDR_WIDTH-1:0] im_address,
   output logic [31:0]           im_data,
   output logic                  core_rst,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_CHK, ST_RUN, ST_ERROR} state_t;
`else
   typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_RUN} state_t;
`endif

   state_t                state_q;
   logic                  in_ready_q;
   logic                  im_wren_q;
   logic [ADDR_WIDTH-1:0] im_address_q;
   logic [31:0]           im_data_q;
   logic                  core_rst_q;
   logic                  done_q;
   logic [ADDR_WIDTH:0]   words_loaded_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH-1:0] word_idx_q;
   logic [1:0]            byte_idx_q;
   logic [23:0]           shift_q;
`ifdef CHECKSUM_EN
   logic [7:0]            csum_q;
   logic                  error_q;
`endif

   logic                  hs_d;
   logic [31:0]           word_d;
   logic [ADDR_WIDTH:0]   count_d;
   logic                  last_word_d;
   logic                  restart_d;

   // Handshake, assembled word, decoded header count and end-of-image detection
   always_comb begin
      hs_d        = in_valid && in_ready_q;
      word_d      = {in_data, shift_q};
      count_d     = (in_data[ADDR_WIDTH-1:0] == '0) ? (ADDR_WIDTH+1)'(DEPTH)
                                                    : {1'b0, in_data[ADDR_WIDTH-1:0]};
      last_word_d = ((words_loaded_q + (ADDR_WIDTH+1)'(1)) == count_q);
`ifdef CHECKSUM_EN
      restart_d   = reload && ((state_q == ST_RUN) || (state_q == ST_ERROR));
`else
      restart_d   = reload && (state_q == ST_RUN);
`endif
   end

   // Load sequencer: header, packed data words, optional checksum, then run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_HDR;
         in_ready_q     <= 1'b1;
         im_wren_q      <= 1'b0;
         im_address_q   <= '0;
         im_data_q      <= '0;
         core_rst_q     <= 1'b1;
         done_q         <= 1'b0;
         words_loaded_q <= '0;
         count_q        <= '0;
         word_idx_q     <= '0;
         byte_idx_q     <= '0;
         shift_q        <= '0;
`ifdef CHECKSUM_EN
         csum_q         <= '0;
         error_q        <= 1'b0;
`endif
      end else begin
         im_wren_q <= 1'b0;
         if (restart_d) begin
            state_q        <= ST_HDR;
            in_ready_q     <= 1'b1;
            core_rst_q     <= 1'b1;
            done_q         <= 1'b0;
            words_loaded_q <= '0;
            word_idx_q     <= '0;
            byte_idx_q     <= '0;
`ifdef CHECKSUM_EN
            csum_q         <= '0;
            error_q        <= 1'b0;
`endif
         end else begin
            case (state_q)
               ST_HDR: begin
                  if (hs_d) begin
                     count_q <= count_d;
                     state_q <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (hs_d) begin
                     byte_idx_q <= byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
                     csum_q     <= csum_q ^ in_data;
`endif
                     if (byte_idx_q != 2'd3) begin
                        shift_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
                     end else begin
                        // Word complete: the write pulse lands in the next cycle while
                        // the shift register is already free for the following byte.
                        im_wren_q      <= 1'b1;
                        im_address_q   <= word_idx_q;
                        im_data_q      <= word_d;
                        word_idx_q     <= word_idx_q + ADDR_WIDTH'(1);
                        words_loaded_q <= words_loaded_q + (ADDR_WIDTH+1)'(1);
                        if (last_word_d) begin
`ifdef CHECKSUM_EN
                           state_q    <= ST_CHK;
`else
                           state_q    <= ST_RUN;
                           in_ready_q <= 1'b0;
`endif
                        end
                     end
                  end
               end
`ifdef CHECKSUM_EN
               ST_CHK: begin
                  if (hs_d) begin
                     in_ready_q <= 1'b0;
                     if (in_data == csum_q) begin
                        state_q <= ST_RUN;
                     end else begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                     end
                  end
               end
               ST_ERROR: begin
                  core_rst_q <= 1'b1;
                  done_q     <= 1'b0;
               end
`endif
               ST_RUN: begin
                  // Released one cycle after entry, so the final write has landed
                  core_rst_q <= 1'b0;
                  done_q     <= 1'b1;
               end
               default: begin
                  state_q <= ST_HDR;
               end
            endcase
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign im_wren      = im_wren_q;
   assign im_address   = im_address_q;
   assign im_data      = im_data_q;
   assign core_rst     = core_rst_q;
   assign done         = done_q;
   assign words_loaded = words_loaded_q;
`ifdef CHECKSUM_EN
   assign error        = error_q;
`else
   assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: cycle-exact vector table plus
// directed multi-cycle sequences (random valid, full wrap load, mid-load reset, checksum).
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        reload = 1'b0;
   logic        im_wren;
   logic [5:0]  im_address;
   logic [31:0] im_data;
   logic        core_rst;
   logic        done;
   logic        error;
   logic [6:0]  words_loaded;

   int nvec = 0;
   int nerr = 0;

   logic [5:0]  wq_addr[$];
   logic [31:0] wq_data[$];

   imem_boot_loader #(.ADDR_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .reload(reload), .im_wren(im_wren), .im_address(im_address), .im_data(im_data),
      .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Capture every memory write, sampled away from the active edge
   always @(negedge clk) begin
      if (!rst && im_wren) begin
         wq_addr.push_back(im_address);
         wq_data.push_back(im_data);
      end
   end

   typedef struct {
      logic        vld;
      logic [7:0]  din;
      logic        rld;
      logic        wren;
      logic [5:0]  addr;
      logic [31:0] data;
      logic        crst;
      logic        dn;
      logic        rdy;
      logic [6:0]  wl;
   } vec_t;

   function automatic vec_t mk(logic vld, logic [7:0] din, logic rld, logic wren,
                               logic [5:0] addr, logic [31:0] data, logic crst,
                               logic dn, logic rdy, logic [6:0] wl);
      vec_t v;
      v.vld = vld; v.din = din; v.rld = rld; v.wren = wren; v.addr = addr;
      v.data = data; v.crst = crst; v.dn = dn; v.rdy = rdy; v.wl = wl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      bit sent = 1'b0;
      int tries = 0;
      while (!sent) begin
         @(negedge clk);
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? b : 8'($urandom);
         if (in_valid && in_ready) sent = 1'b1;
         @(posedge clk);
         tries++;
         if (!sent && tries > 60) begin
            nvec++;
            nerr++;
            $display("FAIL send_byte timeout: byte 0x%0h not accepted, in_ready=%0b", b, in_ready);
            sent = 1'b1;
         end
      end
   endtask

   // Header plus data bytes; with the checksum option a trailing XOR byte is appended
   task automatic load(input logic [7:0] bs[$], input bit rnd, input bit bad);
      logic [7:0] x = 8'h00;
      foreach (bs[i]) begin
         send_byte(bs[i], rnd);
         if (i > 0) x ^= bs[i];
      end
`ifdef CHECKSUM_EN
      send_byte(x ^ {7'd0, bad}, rnd);
`else
      x = x ^ {7'd0, bad};
`endif
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("core released (done)", 64'(done), 64'd1);
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wq_addr.delete();
      wq_data.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[18];
      logic [7:0]  q[$];
      logic [48:0] got, exp;

      vecs[0]  = mk(1, 8'h02, 0, 0, 0, 0,            1, 0, 1, 0);
      vecs[1]  = mk(1, 8'h13, 0, 0, 0, 0,            1, 0, 1, 0);
      vecs[2]  = mk(1, 8'h00, 0, 0, 0, 0,            1, 0, 1, 0);
      vecs[3]  = mk(1, 8'h08, 0, 0, 0, 0,            1, 0, 1, 0);
      vecs[4]  = mk(1, 8'h20, 0, 1, 0, 32'h20080013, 1, 0, 1, 1);
      vecs[5]  = mk(1, 8'h01, 0, 0, 0, 0,            1, 0, 1, 1);
      vecs[6]  = mk(1, 8'h00, 0, 0, 0, 0,            1, 0, 1, 1);
      vecs[7]  = mk(1, 8'h09, 0, 0, 0, 0,            1, 0, 1, 1);
      vecs[8]  = mk(1, 8'h21, 0, 1, 1, 32'h21090001, 1, 0, 0, 2);
      vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0,            0, 1, 0, 2);
      vecs[10] = mk(1, 8'hFF, 0, 0, 0, 0,            0, 1, 0, 2);
      vecs[11] = mk(0, 8'h00, 1, 0, 0, 0,            1, 0, 1, 0);
      vecs[12] = mk(1, 8'h01, 0, 0, 0, 0,            1, 0, 1, 0);
      vecs[13] = mk(1, 8'h00, 1, 0, 0, 0,            1, 0, 1, 0);
      vecs[14] = mk(1, 8'h00, 0, 0, 0, 0,            1, 0, 1, 0);
      vecs[15] = mk(1, 8'h00, 1, 0, 0, 0,            1, 0, 1, 0);
      vecs[16] = mk(1, 8'h00, 0, 1, 0, 32'h00000000, 1, 0, 0, 1);
      vecs[17] = mk(0, 8'h00, 0, 0, 0, 0,            0, 1, 0, 1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset core_rst", 64'(core_rst), 64'd1);
      chk("reset im_wren/im_address/im_data", {31'd0, im_wren, im_address, im_data}, 64'd0);
      chk("reset done/error/words_loaded", {55'd0, done, error, words_loaded}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

`ifndef CHECKSUM_EN
      // Two-word load at 1 byte/clk, then reload and a one-word load (reload in DATA ignored)
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         in_valid = vecs[i].vld;
         in_data  = vecs[i].din;
         reload   = vecs[i].rld;
         @(posedge clk);
         #1;
         got = {im_wren, core_rst, done, in_ready, words_loaded,
                im_wren ? {im_address, im_data} : 38'd0};
         exp = {vecs[i].wren, vecs[i].crst, vecs[i].dn, vecs[i].rdy, vecs[i].wl,
                vecs[i].wren ? {vecs[i].addr, vecs[i].data} : 38'd0};
         chk($sformatf("table vector %0d", i), 64'(got), 64'(exp));
      end
      @(negedge clk);
      in_valid = 1'b0;
      reload   = 1'b0;
`endif

      // Same two-word stream with in_valid toggled randomly
      do_reset();
      q = '{8'h02, 8'h13, 8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h09, 8'h21};
      load(q, 1'b1, 1'b0);
      wait_done();
      chk("random-valid write count", 64'(wq_addr.size()), 64'd2);
      if (wq_addr.size() == 2) begin
         chk("random-valid write 0", {26'd0, wq_addr[0], wq_data[0]}, {26'd0, 6'd0, 32'h20080013});
         chk("random-valid write 1", {26'd0, wq_addr[1], wq_data[1]}, {26'd0, 6'd1, 32'h21090001});
      end
      chk("random-valid words_loaded", 64'(words_loaded), 64'd2);

      // Full load: header 00 means 64 words, address wraps afterwards
      do_reset();
      q.delete();
      q.push_back(8'h00);
      for (int i = 0; i < 64; i++) repeat (4) q.push_back(8'(i));
      load(q, 1'b0, 1'b0);
      wait_done();
      repeat (3) @(negedge clk);
      chk("full-load write count", 64'(wq_addr.size()), 64'd64);
      for (int i = 0; i < 64 && i < wq_addr.size(); i++) begin
         chk($sformatf("full-load write %0d", i), {26'd0, wq_addr[i], wq_data[i]},
             {26'd0, 6'(i), {4{8'(i)}}});
      end
      chk("full-load words_loaded", 64'(words_loaded), 64'd64);

      // Reset in the middle of a load, then a fresh one-word image
      do_reset();
      q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      foreach (q[i]) send_byte(q[i], 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid-load reset outputs", {57'd0, core_rst, done, in_ready, im_wren, words_loaded[2:0]},
          {57'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0});
      do_reset();
      q = '{8'h01, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      load(q, 1'b0, 1'b0);
      chk("core held during final write", 64'(core_rst), 64'd1);
      wait_done();
      chk("post-reset write count", 64'(wq_addr.size()), 64'd1);
      if (wq_addr.size() == 1)
         chk("post-reset write", {26'd0, wq_addr[0], wq_data[0]}, {26'd0, 6'd0, 32'hAABBCCDD});

`ifdef CHECKSUM_EN
      // Checksum good, then bad, then recovery through reload
      do_reset();
      q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      load(q, 1'b0, 1'b0);
      wait_done();
      chk("checksum ok error", 64'(error), 64'd0);
      pulse_reload();
      load(q, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      chk("checksum bad flags", {60'd0, error, in_ready, core_rst, done}, {60'd0, 4'b1010});
      pulse_reload();
      chk("reload from error", {61'd0, error, in_ready, core_rst}, {61'd0, 3'b011});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
